// File: rtl/uart_rx_frame.sv
// UART frame receiver: 3-sample majority per bit, start-bit re-check, parity and stop checks.
// Sticky result flags are visible HALF+3+(bits after start)*CLKS_PER_BIT cycles after the start edge is seen.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT   = 8,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 1,
  parameter int STOP_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int SYNC_DELAY     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  input  logic                 start_rx,
  output logic                 busy,
  output logic                 is_byte_valid,
  output logic                 is_byte_corrupt,
  output logic                 is_frame_error,
  output logic                 is_rx_timeout,
  output logic [DATA_BITS-1:0] dout
);

  localparam int         HALF      = CLKS_PER_BIT / 2 - 1;
  localparam logic [7:0] HALF_C    = 8'(HALF);
  localparam logic [7:0] BIT_END   = 8'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CHECK_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_DELAY:0]    sync_q;
  logic                   hist_q;
  logic [7:0]             timer_q, timer_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [15:0]            to_cnt_q, to_cnt_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   par_bit_q, par_bit_d;
  logic                   frame_err_q, frame_err_d;
  logic                   valid_q, valid_d;
  logic                   corrupt_q, corrupt_d;
  logic                   ferr_q, ferr_d;
  logic                   timeout_q, timeout_d;

  logic        s;
  logic        fall;
  logic        maj;
  logic        bit_tick;
  logic        par_xor;
  logic        par_fail;
  logic [15:0] to_cnt_inc;

  // sync_q[k-1] is stage k of the delay line; s is stage SYNC_DELAY
  assign s    = sync_q[SYNC_DELAY-1];
  assign fall = sync_q[SYNC_DELAY] & ~s;
  assign maj  = (hist_q & sync_q[SYNC_DELAY]) | (hist_q & s) | (sync_q[SYNC_DELAY] & s);

  assign bit_tick   = (state_q == S_CHECK_START) ? (timer_q == HALF_C) : (timer_q == BIT_END);
  assign to_cnt_inc = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + 16'd1;

  assign par_xor  = (^data_q) ^ par_bit_q;
  assign par_fail = (PARITY == 1) ? ~par_xor : ((PARITY == 2) ? par_xor : 1'b0);

  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    data_d      = data_q;
    par_bit_d   = par_bit_q;
    frame_err_d = frame_err_q;
    valid_d     = valid_q;
    corrupt_d   = corrupt_q;
    ferr_d      = ferr_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start_rx) begin
          valid_d     = 1'b0;
          corrupt_d   = 1'b0;
          ferr_d      = 1'b0;
          timeout_d   = 1'b0;
          data_d      = '0;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          par_bit_d   = 1'b0;
          frame_err_d = 1'b0;
          state_d     = S_WAIT_START;
        end
      end

      S_WAIT_START: begin
        to_cnt_d = to_cnt_inc;
        if (fall) begin
          state_d = S_CHECK_START;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_CHECK_START: begin
        // the timeout keeps running here so repeated glitches cannot extend the wait
        to_cnt_d = to_cnt_inc;
        timer_d  = timer_q + 8'd1;
        if (bit_tick) begin
          timer_d = '0;
          state_d = maj ? S_WAIT_START : S_DATA;
        end
      end

      S_DATA: begin
        timer_d = timer_q + 8'd1;
        if (bit_tick) begin
          timer_d = '0;
          data_d  = {maj, data_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_PARITY: begin
        timer_d = timer_q + 8'd1;
        if (bit_tick) begin
          timer_d   = '0;
          par_bit_d = maj;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        timer_d = timer_q + 8'd1;
        if (bit_tick) begin
          timer_d = '0;
          if (!maj) begin
            frame_err_d = 1'b1;
          end
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_DONE: begin
        corrupt_d = par_fail;
        ferr_d    = frame_err_q;
        valid_d   = ~par_fail & ~frame_err_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      hist_q      <= 1'b1;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      data_q      <= '0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
      valid_q     <= 1'b0;
      corrupt_q   <= 1'b0;
      ferr_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_DELAY-1:0], din};
      hist_q      <= sync_q[SYNC_DELAY];
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      data_q      <= data_d;
      par_bit_q   <= par_bit_d;
      frame_err_q <= frame_err_d;
      valid_q     <= valid_d;
      corrupt_q   <= corrupt_d;
      ferr_q      <= ferr_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign is_byte_valid   = valid_q;
  assign is_byte_corrupt = corrupt_q;
  assign is_frame_error  = ferr_q;
  assign is_rx_timeout   = timeout_q;
  assign dout            = data_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: default instance plus a 16x/7-bit/even/1-stop instance,
// frames built from bit lists and results predicted from the framing rules.
module tb_uart_rx_frame;

  localparam int SD = 4;
  localparam int TO = 2000;

  int cfg_cpb [2] = '{8, 16};
  int cfg_db  [2] = '{8, 7};
  int cfg_par [2] = '{1, 2};
  int cfg_sb  [2] = '{2, 1};

  logic       clk;
  logic       rst_n;
  logic       din0, din1, st0, st1;
  logic       busy0, vld0, cor0, fe0, to0;
  logic       busy1, vld1, cor1, fe1, to1;
  logic [7:0] dout0;
  logic [6:0] dout1;

  int n_cmp;
  int n_bad;

  uart_rx_frame u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .start_rx(st0), .busy(busy0),
    .is_byte_valid(vld0), .is_byte_corrupt(cor0), .is_frame_error(fe0),
    .is_rx_timeout(to0), .dout(dout0)
  );

  uart_rx_frame #(
    .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .start_rx(st1), .busy(busy1),
    .is_byte_valid(vld1), .is_byte_corrupt(cor1), .is_frame_error(fe1),
    .is_rx_timeout(to1), .dout(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_din(input int u, input logic v);
    if (u == 0) din0 = v;
    else din1 = v;
  endtask

  task automatic set_start(input int u, input logic v);
    if (u == 0) st0 = v;
    else st1 = v;
  endtask

  // {valid, corrupt, frame_error, timeout}
  function automatic logic [3:0] flags_of(input int u);
    return (u == 0) ? {vld0, cor0, fe0, to0} : {vld1, cor1, fe1, to1};
  endfunction

  function automatic logic [31:0] dout_of(input int u);
    return (u == 0) ? 32'(dout0) : 32'(dout1);
  endfunction

  function automatic logic busy_of(input int u);
    return (u == 0) ? busy0 : busy1;
  endfunction

  // stop_mask bit k is the level of stop bit k; glitch_bit indexes the wire bit list (0 = start)
  task automatic run_frame(input int u, input int data, input int par_bit, input int stop_mask,
                           input int glitch_bit, input int gap, input bit poke, input string tag);
    int   cpb, db, par, sb, half, wlen, f_cyc, last, ones, exp_dout;
    bit   par_ok, fe;
    logic v;
    logic [3:0] exp_flags;
    logic bits[$];

    cpb = cfg_cpb[u]; db = cfg_db[u]; par = cfg_par[u]; sb = cfg_sb[u];
    exp_dout = data & ((1 << db) - 1);
    bits.push_back(1'b0);
    for (int b = 0; b < db; b++) bits.push_back(exp_dout[b]);
    if (par != 0) bits.push_back(par_bit[0]);
    for (int k = 0; k < sb; k++) bits.push_back(stop_mask[k]);

    ones   = $countones(exp_dout);
    par_ok = (par == 0) || (par == 1 && ((ones + par_bit) % 2 == 1)) ||
             (par == 2 && ((ones + par_bit) % 2 == 0));
    fe     = (stop_mask & ((1 << sb) - 1)) != ((1 << sb) - 1);
    exp_flags = {par_ok && !fe, !par_ok, fe, 1'b0};

    half  = cpb / 2 - 1;
    wlen  = bits.size() * cpb;
    f_cyc = SD + half + 3 + (bits.size() - 1) * cpb;
    last  = (f_cyc > wlen - 1) ? f_cyc : wlen - 1;

    set_start(u, 1'b1);
    tick;
    set_start(u, 1'b0);
    chk({tag, " armed busy"}, 32'(busy_of(u)), 1);
    chk({tag, " armed flags"}, 32'(flags_of(u)), 0);
    chk({tag, " armed dout"}, dout_of(u), 0);
    for (int g = 0; g < gap; g++) begin
      set_din(u, 1'b1);
      tick;
    end

    for (int i = 0; i <= last; i++) begin
      set_start(u, 1'b0);
      if (i == f_cyc - 1) begin
        chk({tag, " pre busy"}, 32'(busy_of(u)), 1);
        chk({tag, " pre flags"}, 32'(flags_of(u)), 0);
      end
      if (i == f_cyc) begin
        chk({tag, " flags"}, 32'(flags_of(u)), 32'(exp_flags));
        chk({tag, " dout"}, dout_of(u), 32'(exp_dout));
        chk({tag, " busy"}, 32'(busy_of(u)), 0);
      end
      if (i == last) break;
      if (poke && i == wlen / 2) set_start(u, 1'b1);
      if (i < wlen) begin
        v = bits[i / cpb];
        if ((i / cpb) == glitch_bit && (i % cpb) == cpb / 2) v = ~v;
      end else begin
        v = 1'b1;
      end
      set_din(u, v);
      tick;
    end
    set_din(u, 1'b1);
  endtask

  // start_rx is driven in cycle 0; the line stays idle apart from an optional glitch
  task automatic run_timeout(input bit glitch, input string tag);
    set_start(0, 1'b1);
    tick;
    set_start(0, 1'b0);
    for (int c = 1; c <= TO + 1; c++) begin
      if (c == TO) begin
        chk({tag, " before flags"}, 32'(flags_of(0)), 0);
        chk({tag, " before busy"}, 32'(busy_of(0)), 1);
      end
      if (c == TO + 1) begin
        chk({tag, " flags"}, 32'(flags_of(0)), 32'h1);
        chk({tag, " busy"}, 32'(busy_of(0)), 0);
        chk({tag, " dout"}, dout_of(0), 0);
        break;
      end
      set_din(0, !(glitch && (c == 100 || c == 101)));
      tick;
    end
    set_din(0, 1'b1);
  endtask

  task automatic run_reset_abort;
    logic [7:0] d;
    d = 8'hA5;
    set_start(0, 1'b1);
    tick;
    set_start(0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      set_din(0, (i < 8) ? 1'b0 : d[(i - 8) / 8]);
      tick;
    end
    chk("abort mid busy", 32'(busy_of(0)), 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy_of(0)), 0);
    chk("abort flags", 32'(flags_of(0)), 0);
    chk("abort dout", dout_of(0), 0);
    set_din(0, 1'b1);
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  initial begin
    int u, db, par, ones, good_par, pb, sm, gb, nbits;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    din0 = 1'b1; din1 = 1'b1; st0 = 1'b0; st1 = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset busy%0d", k), 32'(busy_of(k)), 0);
      chk($sformatf("reset flags%0d", k), 32'(flags_of(k)), 0);
      chk($sformatf("reset dout%0d", k), dout_of(k), 0);
    end

    run_frame(0, 'hA5, 1, 3, -1, 3, 1'b0, "a5_ok");
    run_frame(0, 'hA5, 0, 3, -1, 2, 1'b0, "a5_par");
    run_frame(0, 'h3C, 1, 1, -1, 2, 1'b0, "3c_stop");
    run_frame(0, 'h5A, 1, 3, 4, 2, 1'b1, "5a_glitch");
    run_timeout(1'b0, "to_plain");
    run_timeout(1'b1, "to_glitch");
    run_frame(1, 'h41, 0, 1, -1, 2, 1'b0, "41_even_ok");
    run_frame(1, 'h41, 1, 1, -1, 2, 1'b0, "41_even_bad");

    for (int r = 0; r < 50; r++) begin
      u    = r % 2;
      db   = cfg_db[u];
      par  = cfg_par[u];
      pb   = $urandom_range((1 << db) - 1, 0);
      ones = $countones(pb);
      good_par = (par == 1) ? ((ones % 2 == 0) ? 1 : 0) : (ones % 2);
      gb   = good_par;
      if ($urandom_range(3, 0) == 0) gb = 1 - good_par;
      sm   = ($urandom_range(4, 0) == 0) ? $urandom_range((1 << cfg_sb[u]) - 1, 0)
                                          : (1 << cfg_sb[u]) - 1;
      nbits = 1 + db + ((par != 0) ? 1 : 0) + cfg_sb[u];
      run_frame(u, pb, gb, sm,
                ($urandom_range(1, 0) == 1) ? $urandom_range(nbits - 1, 1) : -1,
                $urandom_range(6, 1), ($urandom_range(3, 0) == 0),
                $sformatf("rnd%0d", r));
    end

    run_reset_abort();
    run_frame(0, 'h96, 1, 3, -1, 2, 1'b0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART frame receiver for the AMDS sensor-link path; successor to the fixed 25 Mbit/s, 8O2 receiver. Baud divisor, data width, parity mode and stop-bit count are compile-time parameters. Each bit is taken as a 3-sample majority vote. A mid-bit start-bit re-check rejects glitches, and stop bits are checked for framing errors. Sits between the AXI driver's synchronised `din` and the per-channel packet state machines, with one instance per sensor channel.

## Interface
- CLKS_PER_BIT, 8, clk cycles per UART bit; legal range 4..255.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
- PARITY, 1, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 2, number of stop bits, 1 or 2.
- TIMEOUT_CYCLES, 2000, cycles to wait for a start bit after `start_rx`; legal range 2..65535.
- SYNC_DELAY, 4, extra alignment flops on `din` (1..8); the last flop plus one more form the edge detector.
- clk  input  1  system clock (200 MHz nominal).
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  UART line, already double-flopped upstream; idle high.
- start_rx  input  1  single-cycle request to arm the receiver; honoured only in IDLE.
- busy  output  1  high in every state except IDLE.
- is_byte_valid  output  1  sticky: frame received, parity OK, all stop bits high.
- is_byte_corrupt  output  1  sticky: parity check failed.
- is_frame_error  output  1  sticky: at least one stop bit sampled low.
- is_rx_timeout  output  1  sticky: no valid start bit within TIMEOUT_CYCLES.
- dout  output  DATA_BITS  received data; bit 0 is the first bit on the wire.

## Operation
- Delay line: `din` passes through SYNC_DELAY+1 flops, all reset to 1 (idle level).
  - `s` = stage SYNC_DELAY; `fall` = stage SYNC_DELAY+1 high and `s` low.
- Majority sample: `maj` = majority of `s` at the cycles center-1, center, center+1, where center = nominal sample cycle. The decision is made at center+1.
- States: IDLE, WAIT_START, CHECK_START, DATA, PARITY, STOP, DONE.
- IDLE, on `start_rx`:
  - clear all four flags, `dout`, the bit counter and the timeout counter;
  - go to WAIT_START.
- WAIT_START:
  - on `fall`: reset the baud timer, go to CHECK_START;
  - otherwise, when the timeout counter equals TIMEOUT_CYCLES-1: set `is_rx_timeout`, go to IDLE;
  - `fall` wins if both occur in the same cycle.
- CHECK_START: at the start-bit center, if `maj` = 1 the start is false and the state returns to WAIT_START. The timeout counter is not reset on a false start. Otherwise go to DATA.
- DATA:
  - shift `maj` into the MSB of a DATA_BITS register at each bit center (shift right);
  - after DATA_BITS bits go to PARITY, or to STOP if PARITY = 0.
- PARITY: store the sampled bit and go to STOP.
  - Odd mode passes if XOR(data, parity bit) = 1.
  - Even mode passes if XOR(data, parity bit) = 0.
- STOP: sample STOP_BITS bits; any `maj` = 0 latches a framing error. Go to DONE after the last stop sample.
- DONE (one cycle):
  - set `is_byte_corrupt` on parity fail and `is_frame_error` on stop fail;
  - set `is_byte_valid` only if neither fail occurred; corrupt and frame error may both set;
  - go to IDLE.
- `start_rx` is ignored outside IDLE.
- Flags remain set until the next accepted `start_rx`.
- `dout` holds its value until the next accepted `start_rx`, including after a timeout (it reads 0 then).

## Timing
- Reset values: all flags 0, `busy` 0, `dout` 0, state IDLE.
- Reset asserted mid-frame aborts the frame immediately, with no flag set.
- Let t0 be the cycle in which WAIT_START sees `fall`.
  - HALF = CLKS_PER_BIT/2 - 1 (integer division); this compensates for the one-cycle-late edge detection.
  - Start center = t0 + HALF + 1.
  - Bit n center (n = 0 for the first data bit) = t0 + HALF + 1 + (n+1)·CLKS_PER_BIT, counting data, parity and stop bits in wire order.
- The majority decision for a bit is registered at center+1.
- Flags assert in the cycle after DONE; `busy` falls in that same cycle.
- Total latency from t0 to the flags: HALF + 3 + (DATA_BITS + (PARITY≠0) + STOP_BITS)·CLKS_PER_BIT cycles. With defaults this is 94 cycles.
- Timeout:
  - the counter starts at 0 in the cycle after `start_rx`;
  - `is_rx_timeout` is visible TIMEOUT_CYCLES+1 cycles after the `start_rx` cycle;
  - the counter saturates and does not wrap.
- A new `start_rx` may arrive in the same cycle the flags become visible; it is accepted.

## Test plan
- Defaults, frame 0xA5 with parity bit 1 and stop bits 11 -> `dout` = 0xA5, only `is_byte_valid` = 1, 94 cycles after t0.
- Defaults, 0xA5 sent with parity bit 0 -> `is_byte_corrupt` = 1, `is_byte_valid` = 0, `dout` = 0xA5.
- Defaults, 0x3C with the second stop bit driven low -> `is_frame_error` = 1, `is_byte_valid` = 0; a following `start_rx` clears all flags.
- Defaults, `din` held high after `start_rx` -> `is_rx_timeout` = 1 at cycle 2001; a 2-cycle low glitch at cycle 100 is rejected as a false start and still times out at 2001.
- Defaults, frame 0x5A with a 1-cycle inverted glitch at the exact center of bit 3 -> `dout` = 0x5A, valid (majority vote).
- CLKS_PER_BIT=16, DATA_BITS=7, PARITY=2, STOP_BITS=1, frame 0x41 with parity 0 -> `dout` = 0x41, valid; same frame with parity 1 -> `is_byte_corrupt` = 1.
